// File: rtl/fc_argmax_layer_if.sv
// Feature-read, score-stream and result handshake bundle of the fully-connected argmax layer.
// The layer uses the slave modport; the host / feature buffer / UART side uses master.
interface fc_argmax_layer_if #(
  parameter int N_IN    = 16,
  parameter int DIN_W   = 18,
  parameter int FA_W    = 6,
  parameter int CI_W    = 4,
  parameter int SCORE_W = 24
);
  logic                          start;
  logic [N_IN-1:0][DIN_W-1:0]    din;
  logic [FA_W-1:0]               feat_addr;
  logic                          busy;
  logic                          score_valid;
  logic [CI_W-1:0]               score_idx;
  logic signed [SCORE_W-1:0]     score;
  logic                          result_valid;
  logic                          result_ready;
  logic [CI_W-1:0]               class_idx;
  logic signed [SCORE_W-1:0]     max_score;

  modport slave (
    input  start, din, result_ready,
    output feat_addr, busy, score_valid, score_idx, score,
           result_valid, class_idx, max_score
  );

  modport master (
    output start, din, result_ready,
    input  feat_addr, busy, score_valid, score_idx, score,
           result_valid, class_idx, max_score
  );
endinterface

// File: rtl/fc_argmax_layer.sv
// Fully-connected output layer: per-class dot product over N_POS beats of N_IN features,
// bias, optional ReLU, saturation to SCORE_W, and a running argmax held until accepted.
module fc_argmax_layer #(
  parameter int N_IN    = 16,
  parameter int N_POS   = 49,
  parameter int N_CLS   = 10,
  parameter int DIN_W   = 18,
  parameter int W_W     = 9,
  parameter int ACC_W   = 36,
  parameter int SCORE_W = 24,
  parameter int RELU    = 1,
  // Weight ROM i occupies bits [(i*N_CLS*N_POS + c*N_POS + p)*W_W +: W_W]; bias c at [c*W_W +: W_W].
  parameter logic [N_IN*N_CLS*N_POS*W_W-1:0] W_INIT = '0,
  parameter logic [N_CLS*W_W-1:0]            B_INIT = '0
) (
  input  logic               clk,
  input  logic               rst_n,
  fc_argmax_layer_if.slave   bus
);

  localparam int DEPTH  = N_CLS * N_POS;
  localparam int FA_W   = (N_POS > 1) ? $clog2(N_POS) : 1;
  localparam int CI_W   = (N_CLS > 1) ? $clog2(N_CLS) : 1;
  localparam int RA_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PROD_W = DIN_W + W_W;

  typedef enum logic [2:0] {IDLE, PRIME, ACC, BIAS, HOLD} state_t;

  state_t                    state;
  logic [CI_W-1:0]           cls;
  logic [FA_W-1:0]           pos;
  logic [RA_W-1:0]           rom_addr;
  logic [RA_W-1:0]           rom_base;
  logic signed [ACC_W-1:0]   acc;
  logic [CI_W-1:0]           best_idx;
  logic signed [SCORE_W-1:0] best_score;

  logic [W_W-1:0]            w_rom [N_IN][DEPTH];
  logic [W_W-1:0]            b_rom [N_CLS];
  logic [W_W-1:0]            w_q   [N_IN];

  logic signed [ACC_W-1:0]   beat_sum;
  logic signed [ACC_W-1:0]   biased;
  logic signed [ACC_W-1:0]   relu_s;
  logic [ACC_W-SCORE_W:0]    relu_hi;
  logic signed [SCORE_W-1:0] sat_s;

  for (genvar i = 0; i < N_IN; i++) begin : g_wrom
    for (genvar j = 0; j < DEPTH; j++) begin : g_word
      assign w_rom[i][j] = W_INIT[(i*DEPTH + j)*W_W +: W_W];
    end
  end

  for (genvar c = 0; c < N_CLS; c++) begin : g_brom
    assign b_rom[c] = B_INIT[c*W_W +: W_W];
  end

  // NOTE: the ROM output register has no reset; PRIME always refills it before ACC consumes it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < N_IN; i++) begin
      w_q[i] <= (int'(rom_addr) < DEPTH) ? w_rom[i][rom_addr] : '0;
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path can infer a latch.
    beat_sum = '0;
    for (int i = 0; i < N_IN; i++) begin
      logic signed [PROD_W-1:0] prod;
      prod     = $signed(bus.din[i]) * $signed(w_q[i]);
      beat_sum = beat_sum + ACC_W'(prod);
    end
  end

  always_comb begin
    biased  = acc + ACC_W'($signed(b_rom[cls]));
    relu_s  = ((RELU != 0) && biased[ACC_W-1]) ? '0 : biased;
    // The value fits SCORE_W when all bits above the score sign bit agree with it.
    relu_hi = relu_s[ACC_W-1:SCORE_W-1];
    if ((relu_hi == '0) || (relu_hi == '1)) begin
      sat_s = relu_s[SCORE_W-1:0];
    end else if (relu_s[ACC_W-1]) begin
      sat_s = {1'b1, {(SCORE_W-1){1'b0}}};
    end else begin
      sat_s = {1'b0, {(SCORE_W-1){1'b1}}};
    end
  end

  // NOTE: all state and registered outputs use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      cls              <= '0;
      pos              <= '0;
      rom_addr         <= '0;
      rom_base         <= '0;
      acc              <= '0;
      best_idx         <= '0;
      best_score       <= '0;
      bus.feat_addr    <= '0;
      bus.busy         <= 1'b0;
      bus.score_valid  <= 1'b0;
      bus.score_idx    <= '0;
      bus.score        <= '0;
      bus.result_valid <= 1'b0;
      bus.class_idx    <= '0;
      bus.max_score    <= '0;
    end else begin
      bus.score_valid <= 1'b0;
      unique case (state)
        IDLE: begin
          if (bus.start) begin
            state         <= PRIME;
            cls           <= '0;
            bus.feat_addr <= '0;
            rom_addr      <= '0;
            rom_base      <= '0;
            bus.busy      <= 1'b1;
          end
        end
        PRIME: begin
          acc           <= '0;
          pos           <= '0;
          bus.feat_addr <= bus.feat_addr + FA_W'(1);
          rom_addr      <= rom_addr + RA_W'(1);
          state         <= ACC;
        end
        ACC: begin
          acc           <= acc + beat_sum;
          bus.feat_addr <= bus.feat_addr + FA_W'(1);
          rom_addr      <= rom_addr + RA_W'(1);
          if (pos == FA_W'(N_POS - 1)) state <= BIAS;
          else                         pos   <= pos + FA_W'(1);
        end
        BIAS: begin
          bus.score_valid <= 1'b1;
          bus.score_idx   <= cls;
          bus.score       <= sat_s;
          // Strict compare: an equal later score keeps the lower class index.
          if ((cls == '0) || (sat_s > best_score)) begin
            best_idx   <= cls;
            best_score <= sat_s;
          end
          if (cls == CI_W'(N_CLS - 1)) begin
            state <= HOLD;
          end else begin
            cls           <= cls + CI_W'(1);
            bus.feat_addr <= '0;
            rom_base      <= rom_base + RA_W'(N_POS);
            rom_addr      <= rom_base + RA_W'(N_POS);
            state         <= PRIME;
          end
        end
        HOLD: begin
          if (!bus.result_valid) begin
            bus.result_valid <= 1'b1;
            bus.busy         <= 1'b0;
            bus.class_idx    <= best_idx;
            bus.max_score    <= best_score;
          end else if (bus.result_ready) begin
            bus.result_valid <= 1'b0;
            state            <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fc_argmax_layer.sv
// Directed bench for fc_argmax_layer: five small instances (2 inputs, 3 beats, 4 classes) with
// different weight sets, a feature-buffer model, and a score scoreboard.
module tb_fc_argmax_layer;

  localparam int NI    = 2;
  localparam int NP    = 3;
  localparam int NC    = 4;
  localparam int NK    = 5;
  localparam int DEPTH = NC * NP;
  localparam int LAT   = NC * (NP + 2) + 1;

  typedef struct { int idx; longint sc; } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                 start_v [NK];
  logic                 ready_v [NK];
  logic [1:0]           fa_v    [NK];
  logic                 busy_v  [NK];
  logic                 sv_v    [NK];
  logic [1:0]           si_v    [NK];
  logic signed [23:0]   sc_v    [NK];
  logic                 rv_v    [NK];
  logic [1:0]           ci_v    [NK];
  logic signed [23:0]   mx_v    [NK];
  logic [NI-1:0][17:0]  din_bus;
  logic [17:0]          fbuf0 [4];
  logic [17:0]          fbuf1 [4];

  int   sel;
  int   n_checks = 0;
  int   errors   = 0;
  exp_t sb[$];
  exp_t mon_e;

  function automatic int wval(int k, int i, int c, int p);
    if (k == 0) return 0;
    if (k == 1) return (i == 0) ? 1 : 2;
    if (k == 2 || k == 3) begin
      if (i == 1) return 0;
      if (c == 2) return (p == 0) ? -5 : (p == 1) ? -6 : -11;
      return (p == 0) ? -4 : (p == 1) ? 0 : -2;
    end
    if (c == 0) return 255;
    if (c == 1) return -256;
    if (c == 2) return 0;
    return 1;
  endfunction

  function automatic logic [NI*DEPTH*9-1:0] w_init(int k);
    logic [NI*DEPTH*9-1:0] r;
    r = '0;
    for (int i = 0; i < NI; i++)
      for (int c = 0; c < NC; c++)
        for (int p = 0; p < NP; p++)
          r[(i*DEPTH + c*NP + p)*9 +: 9] = 9'(wval(k, i, c, p));
    return r;
  endfunction

  function automatic logic [NC*9-1:0] b_init(int k);
    logic [NC*9-1:0] r;
    r = '0;
    if (k == 0) begin
      r[0*9 +: 9] = 9'd5;
      r[1*9 +: 9] = 9'd9;
      r[2*9 +: 9] = 9'd9;
      r[3*9 +: 9] = 9'd2;
    end
    return r;
  endfunction

  function automatic int relu_of(int k);
    return (k == 3 || k == 4) ? 0 : 1;
  endfunction

  for (genvar k = 0; k < NK; k++) begin : g_dut
    fc_argmax_layer_if #(.N_IN(NI), .DIN_W(18), .FA_W(2), .CI_W(2), .SCORE_W(24)) bus ();
    assign bus.start        = start_v[k];
    assign bus.din          = din_bus;
    assign bus.result_ready = ready_v[k];
    assign fa_v[k]   = bus.feat_addr;
    assign busy_v[k] = bus.busy;
    assign sv_v[k]   = bus.score_valid;
    assign si_v[k]   = bus.score_idx;
    assign sc_v[k]   = bus.score;
    assign rv_v[k]   = bus.result_valid;
    assign ci_v[k]   = bus.class_idx;
    assign mx_v[k]   = bus.max_score;

    fc_argmax_layer #(
      .N_IN(NI), .N_POS(NP), .N_CLS(NC), .DIN_W(18), .W_W(9), .ACC_W(36), .SCORE_W(24),
      .RELU(relu_of(k)), .W_INIT(w_init(k)), .B_INIT(b_init(k))
    ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
    );
  end

  // Feature buffer: registered read, data valid one cycle after the address.
  always @(posedge clk) din_bus <= {fbuf1[fa_v[sel]], fbuf0[fa_v[sel]]};

  task automatic check(string tag, logic signed [63:0] obs, logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n === 1'b1 && sv_v[sel] === 1'b1) begin
      if (sb.size() == 0) begin
        check("spurious_score_valid", sv_v[sel], 0);
      end else begin
        mon_e = sb.pop_front();
        check($sformatf("score_idx_c%0d", mon_e.idx), si_v[sel], mon_e.idx);
        check($sformatf("score_c%0d", mon_e.idx), sc_v[sel], mon_e.sc);
      end
    end
  end

  task automatic set_feats(int a0, int a1, int a2, int b0, int b1, int b2);
    fbuf0[0] = 18'(a0); fbuf0[1] = 18'(a1); fbuf0[2] = 18'(a2); fbuf0[3] = '0;
    fbuf1[0] = 18'(b0); fbuf1[1] = 18'(b1); fbuf1[2] = 18'(b2); fbuf1[3] = '0;
  endtask

  task automatic start_run(int k, longint s0, longint s1, longint s2, longint s3);
    exp_t e;
    sel = k;
    e.idx = 0; e.sc = s0; sb.push_back(e);
    e.idx = 1; e.sc = s1; sb.push_back(e);
    e.idx = 2; e.sc = s2; sb.push_back(e);
    e.idx = 3; e.sc = s3; sb.push_back(e);
    @(negedge clk);
    start_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[k] = 1'b0;
    check("busy_after_start", busy_v[k], 1);
  endtask

  task automatic wait_result(int k, int cls, longint mx);
    int cyc = 0;
    for (int i = 1; i <= 100; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (rv_v[k] === 1'b1) begin
        cyc = i;
        break;
      end
    end
    check("result_latency", cyc, LAT);
    check("class_idx", ci_v[k], cls);
    check("max_score", mx_v[k], mx);
    check("busy_at_result", busy_v[k], 0);
    check("scores_pending", sb.size(), 0);
  endtask

  task automatic finish_handshake(int k, int cls, longint mx);
    @(negedge clk);
    ready_v[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_v[k] = 1'b0;
    check("valid_after_accept", rv_v[k], 0);
    check("class_after_accept", ci_v[k], cls);
    check("max_after_accept", mx_v[k], mx);
  endtask

  initial begin
    for (int k = 0; k < NK; k++) begin
      start_v[k] = 1'b0;
      ready_v[k] = 1'b0;
    end
    sel = 0;
    set_feats(0, 0, 0, 0, 0, 0);
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #10;
    check("rst_feat_addr", fa_v[0], 0);
    check("rst_busy", busy_v[0], 0);
    check("rst_score_valid", sv_v[0], 0);
    check("rst_result_valid", rv_v[0], 0);
    check("rst_class_idx", ci_v[0], 0);
    check("rst_max_score", mx_v[0], 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Zero weights: scores are the biases, tie on 9 keeps class 1.
    set_feats(7, 7, 7, -2, -2, -2);
    start_run(0, 5, 9, 9, 2);
    wait_result(0, 1, 9);
    finish_handshake(0, 1, 9);

    set_feats(100, 100, 100, -3, -3, -3);
    start_run(1, 282, 282, 282, 282);
    wait_result(1, 0, 282);
    finish_handshake(1, 0, 282);

    // Position-dependent weights on varying features; ReLU on, then off.
    set_feats(1, 2, 3, 5, 5, 5);
    start_run(2, 0, 0, 0, 0);
    wait_result(2, 0, 0);
    finish_handshake(2, 0, 0);
    start_run(3, -10, -10, -50, -10);
    wait_result(3, 0, -10);
    finish_handshake(3, 0, -10);

    set_feats(131071, 131071, 131071, 131071, 131071, 131071);
    start_run(4, 8388607, -8388608, 0, 786426);
    wait_result(4, 0, 8388607);
    finish_handshake(4, 0, 8388607);

    // Result held under back-pressure; a start during HOLD is dropped.
    set_feats(7, 7, 7, -2, -2, -2);
    start_run(0, 5, 9, 9, 2);
    wait_result(0, 1, 9);
    for (int i = 0; i < 50; i++) begin
      if (i == 10) start_v[0] = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start_v[0] = 1'b0;
      check("hold_valid", rv_v[0], 1);
      check("hold_class", ci_v[0], 1);
      check("hold_busy", busy_v[0], 0);
    end
    ready_v[0] = 1'b1;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ready_v[0] = 1'b0;
    start_v[0] = 1'b0;
    check("accept_with_start_valid", rv_v[0], 0);
    check("accept_with_start_busy", busy_v[0], 0);
    repeat (5) @(negedge clk);
    check("start_in_hold_ignored", busy_v[0], 0);
    start_run(0, 5, 9, 9, 2);
    wait_result(0, 1, 9);
    finish_handshake(0, 1, 9);

    // Reset during ACC of class 2 aborts the run without further output.
    start_run(0, 5, 9, 9, 2);
    repeat (12) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("abort_pending", sb.size(), 2);
    check("abort_busy", busy_v[0], 0);
    check("abort_feat_addr", fa_v[0], 0);
    check("abort_score_valid", sv_v[0], 0);
    check("abort_result_valid", rv_v[0], 0);
    check("abort_class_idx", ci_v[0], 0);
    check("abort_max_score", mx_v[0], 0);
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    check("after_abort_busy", busy_v[0], 0);
    check("after_abort_result_valid", rv_v[0], 0);
    start_run(0, 5, 9, 9, 2);
    wait_result(0, 1, 9);
    finish_handshake(0, 1, 9);

    $display("Result: errors=%0d of %0d checks", errors, n_checks);
    $finish;
  end

endmodule
